// File: rtl/pwm_multicanal.sv
// rtl/pwm_multicanal.sv - multi-channel PWM with shared prescaler/counter, edge or center aligned
// Period, duty and mode are double-buffered and only swap in at a period boundary.
module pwm_multicanal #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 5000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      load,
    input  logic                      center_mode,
    input  logic [WIDTH-1:0]          period,
    input  logic [CHANNELS*WIDTH-1:0] duty,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic                      period_start,
    output logic                      pending
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0]             presc_q, presc_d;
    logic [WIDTH-1:0]          cnt_q, cnt_d;
    logic                      dir_down_q, dir_down_d;
    logic [WIDTH-1:0]          per_act_q, per_act_d;
    logic                      mode_act_q, mode_act_d;
    logic [CHANNELS*WIDTH-1:0] duty_act_q, duty_act_d;
    logic [WIDTH-1:0]          per_pend_q, per_pend_d;
    logic                      mode_pend_q, mode_pend_d;
    logic [CHANNELS*WIDTH-1:0] duty_pend_q, duty_pend_d;
    logic                      pending_q, pending_d;
    logic [CHANNELS-1:0]       pwm_q, pwm_d;
    logic                      ps_q, ps_d;
    logic                      tick;
    logic                      boundary;

    // Prescaler, counter and boundary detection
    always_comb begin
        presc_d    = presc_q;
        cnt_d      = cnt_q;
        dir_down_d = dir_down_q;
        tick       = 1'b0;
        boundary   = 1'b0;
        if (!enable) begin
            presc_d    = '0;
            cnt_d      = '0;
            dir_down_d = 1'b0;
        end else begin
            tick    = (presc_q == PRESC_LAST);
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick) begin
                if (per_act_q == '0) begin
                    cnt_d      = '0;
                    dir_down_d = 1'b0;
                    boundary   = 1'b1;
                end else if (!mode_act_q) begin
                    if (cnt_q >= per_act_q) begin
                        cnt_d    = '0;
                        boundary = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (!dir_down_q && (cnt_q < per_act_q)) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    // Turning at the top or descending; reaching 0 closes the period
                    cnt_d      = cnt_q - 1'b1;
                    dir_down_d = 1'b1;
                    if (cnt_q == WIDTH'(1)) begin
                        dir_down_d = 1'b0;
                        boundary   = 1'b1;
                    end
                end
            end
        end
    end

    // Shadow registers: loads land in active directly when disabled or on a boundary clk
    always_comb begin
        per_act_d   = per_act_q;
        mode_act_d  = mode_act_q;
        duty_act_d  = duty_act_q;
        per_pend_d  = per_pend_q;
        mode_pend_d = mode_pend_q;
        duty_pend_d = duty_pend_q;
        pending_d   = pending_q;
        if (load && (!enable || boundary)) begin
            per_act_d  = period;
            mode_act_d = center_mode;
            duty_act_d = duty;
            pending_d  = 1'b0;
        end else if (load) begin
            per_pend_d  = period;
            mode_pend_d = center_mode;
            duty_pend_d = duty;
            pending_d   = 1'b1;
        end else if (boundary && pending_q) begin
            per_act_d  = per_pend_q;
            mode_act_d = mode_pend_q;
            duty_act_d = duty_pend_q;
            pending_d  = 1'b0;
        end
    end

    always_comb begin
        pwm_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            pwm_d[i] = enable & (cnt_q < duty_act_q[i*WIDTH +: WIDTH]);
        end
        ps_d = boundary;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q     <= '0;
            cnt_q       <= '0;
            dir_down_q  <= 1'b0;
            per_act_q   <= '1;
            mode_act_q  <= 1'b0;
            duty_act_q  <= '0;
            per_pend_q  <= '0;
            mode_pend_q <= 1'b0;
            duty_pend_q <= '0;
            pending_q   <= 1'b0;
            pwm_q       <= '0;
            ps_q        <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            cnt_q       <= cnt_d;
            dir_down_q  <= dir_down_d;
            per_act_q   <= per_act_d;
            mode_act_q  <= mode_act_d;
            duty_act_q  <= duty_act_d;
            per_pend_q  <= per_pend_d;
            mode_pend_q <= mode_pend_d;
            duty_pend_q <= duty_pend_d;
            pending_q   <= pending_d;
            pwm_q       <= pwm_d;
            ps_q        <= ps_d;
        end
    end

    assign pwm_out      = pwm_q;
    assign period_start = ps_q;
    assign pending      = pending_q;

endmodule

// File: tb/tb_pwm_multicanal.sv
// tb/tb_pwm_multicanal.sv - scoreboard bench for pwm_multicanal
module tb_pwm_multicanal;
    localparam int CH = 2;
    localparam int W  = 4;
    localparam int PS = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          load;
    logic          center_mode;
    logic [W-1:0]  period;
    logic [CH*W-1:0] duty;
    logic [CH-1:0] pwm_out;
    logic          period_start;
    logic          pending;

    pwm_multicanal #(.CHANNELS(CH), .WIDTH(W), .PRESCALE(PS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .load         (load),
        .center_mode  (center_mode),
        .period       (period),
        .duty         (duty),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .pending      (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        int len;
        int h0;
        int h1;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: a window runs from the clk after one period_start to the next one
    logic mon_armed = 1'b0;
    logic ps_d1 = 1'b0;
    int   win_len = 0;
    int   win_h0 = 0;
    int   win_h1 = 0;
    exp_t e;

    always @(negedge clk) begin
        if (rst_n !== 1'b1 || enable !== 1'b1) begin
            mon_armed = 1'b0;
            ps_d1     = 1'b0;
        end else begin
            if (ps_d1) begin
                if (mon_armed && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("period_len", win_len, e.len);
                    check("high_clks_ch0", win_h0, e.h0);
                    check("high_clks_ch1", win_h1, e.h1);
                end
                mon_armed = 1'b1;
                win_len   = 0;
                win_h0    = 0;
                win_h1    = 0;
            end
            win_len++;
            win_h0 += int'(pwm_out[0]);
            win_h1 += int'(pwm_out[1]);
            ps_d1 = (period_start === 1'b1);
        end
    end

    task automatic push(input int len, input int h0, input int h1);
        exp_t x;
        x.len = len;
        x.h0  = h0;
        x.h1  = h1;
        exp_q.push_back(x);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() > 0) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic do_load(input int p, input int d0, input int d1, input logic cm);
        @(negedge clk);
        period      = W'(p);
        duty        = {W'(d1), W'(d0)};
        center_mode = cm;
        load        = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n       = 1'b0;
        enable      = 1'b1;
        load        = 1'b1;
        center_mode = 1'b0;
        period      = 4'd9;
        duty        = {4'd7, 4'd7};
        repeat (3) begin
            @(negedge clk);
            check("rst_pwm_out", pwm_out, 0);
            check("rst_pending", pending, 0);
            check("rst_period_start", period_start, 0);
        end

        // Disabled load goes straight to active
        enable = 1'b0;
        load   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_load(9, 3, 0, 1'b0);
        check("dis_load_pending", pending, 0);
        check("dis_pwm_out", pwm_out, 0);
        enable = 1'b1;
        push(20, 6, 0);
        push(20, 6, 0);
        drain();

        // Saturation
        do_load(9, 10, 0, 1'b0);
        check("sat_pending_set", pending, 1);
        push(20, 6, 0);
        push(20, 20, 0);
        drain();
        check("sat_pending_clr", pending, 0);
        do_load(9, 15, 0, 1'b0);
        push(20, 20, 0);
        push(20, 20, 0);
        drain();

        // Shadow with overwrite before the boundary
        do_load(9, 3, 0, 1'b0);
        push(20, 20, 0);
        push(20, 6, 0);
        drain();
        repeat (4) @(negedge clk);
        do_load(9, 5, 0, 1'b0);
        check("shadow_pending_a", pending, 1);
        repeat (2) @(negedge clk);
        do_load(9, 7, 0, 1'b0);
        check("shadow_pending_b", pending, 1);
        push(20, 6, 0);
        push(20, 14, 0);
        drain();
        check("shadow_pending_clr", pending, 0);

        // Center-aligned, ch1 duty above P
        do_load(4, 2, 5, 1'b1);
        push(20, 14, 0);
        push(16, 6, 16);
        push(16, 6, 16);
        drain();

        // Back to edge, then abort mid-period
        do_load(9, 3, 0, 1'b0);
        push(16, 6, 16);
        push(20, 6, 0);
        drain();
        repeat (10) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("abort_pwm_out", pwm_out, 0);
        check("abort_period_start", period_start, 0);
        repeat (2) @(negedge clk);
        enable = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (period_start !== 1'b1 && n < 100);
        check("reenable_first_start", n, 20);
        push(20, 6, 0);
        drain();

        // Reset discards pending values
        do_load(9, 15, 0, 1'b0);
        check("rst_pending_set", pending, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_pending", pending, 0);
        check("rst_mid_pwm_out", pwm_out, 0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
